// File: rtl/panda_pkg.sv
// Shared definitions for the Panda fetch stage: FSM states, redirect sources
// and PC step sizes.
package panda_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pc_state_e;

    // Declared in priority order, highest first.
    typedef enum logic [1:0] {
        TRAP   = 2'd0,
        MRET   = 2'd1,
        JUMP   = 2'd2,
        BRANCH = 2'd3
    } redirect_src_e;

    localparam int unsigned PcStepFull = 4;
    localparam int unsigned PcStepHalf = 2;

    // Without compressed support every target must be word aligned.
    function automatic logic target_misaligned(input logic compressed_en,
                                               input logic target_bit1);
        return !compressed_en && target_bit1;
    endfunction

endpackage

// File: rtl/panda_adder.sv
// Generic add/subtract unit shared across the Panda datapath; the result
// wraps modulo 2^Width.
module panda_adder #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] operand_a,
    input  logic [Width-1:0] operand_b,
    input  logic             subtract,
    output logic [Width-1:0] result
);

    logic [Width-1:0] operand_b_eff;

    // Two's-complement subtraction: invert b and inject a carry-in of one.
    assign operand_b_eff = subtract ? ~operand_b : operand_b;
    assign result        = operand_a + operand_b_eff + {{(Width-1){1'b0}}, subtract};

endmodule

// File: rtl/panda_pc_gen.sv
// Program-counter generator for the Panda fetch stage: holds the fetch PC,
// arbitrates redirects and issues fetch requests over valid/ready.
module panda_pc_gen
    import panda_pkg::*;
#(
    parameter int unsigned      Width        = 32,
    parameter logic [Width-1:0] BootAddr     = '0,
    parameter bit               CompressedEn = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_en_i,
    input  logic             stall_i,
    input  logic             trap_i,
    input  logic [Width-1:0] trap_vector_i,
    input  logic             mret_i,
    input  logic [Width-1:0] mepc_i,
    input  logic             jump_i,
    input  logic [Width-1:0] jump_target_i,
    input  logic             branch_i,
    input  logic [Width-1:0] branch_target_i,
    input  logic             compressed_i,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    output logic [Width-1:0] pc_o,
    output logic [Width-1:0] pc_next_o,
    output logic             misaligned_o
);

    pc_state_e        state_q;
    logic [Width-1:0] pc_q;
    logic             pending_q;
    logic             misaligned_q;

    logic             redirect;
    redirect_src_e    redirect_src;
    logic [Width-1:0] redirect_target;
    logic [Width-1:0] redirect_pc;
    logic             redirect_misaligned;

    logic [Width-1:0] step;
    logic             active;
    logic             accept;

    assign step = (CompressedEn && compressed_i) ? Width'(PcStepHalf) : Width'(PcStepFull);

    panda_adder #(
        .Width(Width)
    ) u_adder (
        .operand_a(pc_q),
        .operand_b(step),
        .subtract (1'b0),
        .result   (pc_next_o)
    );

    // Only the highest-priority active source is taken.
    assign redirect = trap_i || mret_i || jump_i || branch_i;

    always_comb begin
        redirect_src = BRANCH;
        if (trap_i) begin
            redirect_src = TRAP;
        end else if (mret_i) begin
            redirect_src = MRET;
        end else if (jump_i) begin
            redirect_src = JUMP;
        end
    end

    always_comb begin
        redirect_target = branch_target_i;
        case (redirect_src)
            TRAP:    redirect_target = trap_vector_i;
            MRET:    redirect_target = mepc_i;
            JUMP:    redirect_target = jump_target_i;
            default: redirect_target = branch_target_i;
        endcase
    end

    assign redirect_pc         = {redirect_target[Width-1:1], 1'b0};
    assign redirect_misaligned = target_misaligned(CompressedEn, redirect_target[1]);

    // A pending request must stay valid even if stall rises underneath it.
    assign active      = (state_q == RUN) || (state_q == DRAIN);
    assign req_valid_o = active && !misaligned_q && (pending_q || !stall_i);
    assign accept      = req_valid_o && req_ready_i;

    assign pc_o         = pc_q;
    assign misaligned_o = misaligned_q;

    // Datapath: a redirect withdraws any request and wins over an advance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= BootAddr;
            pending_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (redirect) begin
            pc_q         <= redirect_pc;
            pending_q    <= 1'b0;
            misaligned_q <= redirect_misaligned;
        end else if (accept) begin
            pc_q      <= pc_next_o;
            pending_q <= 1'b0;
        end else if (req_valid_o) begin
            pending_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en_i && !redirect) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!fetch_en_i) begin
                        if (req_valid_o && !req_ready_i && !redirect) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (accept || redirect) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
